pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage MIPS pipeline (fetch, IF/ID, decode, ID/EX, execute, EX/MEM, data memory, MEM/WB, write-back). It owns the pipeline register write enables and flushes, and drives the fetch `pc_src`. It detects load-use hazards, resolves taken branches from the EX/MEM stage, freezes the pipe on instruction-fetch misses (`hit` low), and generates EX-stage forwarding selects. A small FSM sequences the multi-cycle cases (miss wait, post-branch flush).

## Interface
- `MISS_TIMEOUT`, default 64: max consecutive frozen miss cycles before `miss_timeout` is set.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `hit`  in  1  fetch instruction valid (0 = miss).
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads rt (R-type, beq, sw).
- `ex_mem_read`, `ex_reg_write`  in  1 each  ID/EX control.
- `ex_rs`, `ex_rt`, `ex_write_reg`  in  5 each  ID/EX register fields.
- `mem_branch`, `mem_zero`, `mem_reg_write`  in  1 each  EX/MEM control.
- `mem_write_reg`, `wb_write_reg`  in  5 each  destination registers in MEM and WB.
- `wb_reg_write`  in  1  MEM/WB reg_write.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`, `mem_wb_write`  out  1 each  stage enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  synchronous bubble insert (zero control bits) on the next edge.
- `pc_src`  out  1  select EX/MEM branch target in fetch.
- `fwd_a`, `fwd_b`  out  2 each  ALU operand select: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write data.
- `miss_timeout`  out  1  sticky error flag.
- `state_o`  out  2  current FSM state, for debug.

## Operation
- FSM states: RUN=0, MISS=1, FLUSH=2. Reset state is RUN.
- `branch_taken` = `mem_branch & mem_zero`. It has the highest priority in every state:
  - `pc_src`=1; `if_id_flush`, `id_ex_flush`, `ex_mem_flush`=1; all enables=1.
  - Next state is FLUSH.
  - Any concurrent miss or load-use condition is ignored for that cycle.
- FLUSH lasts exactly one cycle:
  - `if_id_flush`=1 to discard the fetch issued during the redirect.
  - Load-use detection is suppressed.
  - Next state: MISS if `hit`=0, else RUN.
- MISS (entered from RUN when `hit`=0 and no branch is taken):
  - All five enables are 0; no flushes.
  - A miss counter increments each MISS cycle.
  - When `hit`=1, the FSM returns to RUN and the miss counter clears.
  - When the counter reaches `MISS_TIMEOUT`, `miss_timeout` is set. It stays set until reset; the FSM keeps waiting.
- Load-use, evaluated in RUN with `hit`=1 and no branch taken:
  - Condition: `ex_mem_read` & `ex_write_reg`≠0 & (`ex_write_reg`==`id_rs` | (`id_uses_rt` & `ex_write_reg`==`id_rt`)).
  - Response: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1; downstream enables stay 1.
  - Exactly one bubble; the state remains RUN.
- Default outputs in RUN with no event: all enables 1, all flushes 0, `pc_src`=0.
- Forwarding is combinational in every state:
  - EX/MEM has priority over MEM/WB.
  - A source is never forwarded when the destination register is 0.
  - `fwd_a`=10 if `mem_reg_write` & `mem_write_reg`≠0 & `mem_write_reg`==`ex_rs`.
  - Otherwise `fwd_a`=01 on the same test using `wb_reg_write` and `wb_write_reg`.
  - Otherwise `fwd_a`=00.
  - `fwd_b` uses the same rules with `ex_rt`.

## Timing
- Stall, flush and `pc_src` outputs are combinational from the current state and inputs. They take effect on the next rising edge.
- Branch penalty: 3 squashed instructions plus 1 FLUSH cycle.
- Load-use penalty: 1 cycle.
- Miss penalty: the number of cycles `hit` stays low.
- Output values while `rst_n`=0: state RUN, miss counter 0, `miss_timeout`=0, performance counters 0. With `hit`=1 and no hazards this gives all enables 1, flushes 0, `pc_src`=0, `fwd` 00, `state_o`=0.
- Reset asserted mid-MISS or mid-FLUSH returns to RUN immediately; the FSM does not resume the old state.
- The miss counter saturates at `MISS_TIMEOUT`.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds outputs `cnt_load_stall`, `cnt_branch_flush`, `cnt_miss_cycles` (each `CNT_W` bits).
  - Each increments once per stall cycle, taken branch, or MISS cycle respectively.
  - Counters wrap modulo 2^`CNT_W` and reset to 0.
- `HAZARD_PERF_CNT_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - FSM state encoding (RUN, MISS, FLUSH).
  - Forward-select constants `FWD_RF`=00, `FWD_EXMEM`=10, `FWD_MEMWB`=01.
- One sub-module, `forward_unit`: the purely combinational `fwd_a`/`fwd_b` logic, instantiated once.

## Test plan
- `lw $2,0($1)` followed by `add $3,$2,$4` -> one cycle with `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1; then `fwd_a`=01 for the add in EX.
- `add $2,..` followed by `sub $5,$2,$2` -> `fwd_a`=`fwd_b`=10. Same sequence with destination $0 -> 00.
- `beq` taken (`mem_branch`=1, `mem_zero`=1) -> `pc_src`=1 and all three flushes for 1 cycle, then FLUSH with `if_id_flush`=1, then RUN.
- `hit` held 0 for 5 cycles -> all enables 0 for 5 cycles, `state_o`=1, resume on the `hit` rise. With `MISS_TIMEOUT`=4, `miss_timeout` goes 1 and stays 1.
- Taken branch arriving while `hit`=0 and a load-use condition is present -> branch response wins; next state FLUSH.
- `rst_n` pulled low during MISS -> `state_o`=0 asynchronously, counters 0, `miss_timeout` cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller.
// FSM state encoding and forwarding-select constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // EX/MEM beats MEM/WB; register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input logic [4:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && mem_rd != 5'd0 && mem_rd == src)
      sel = FWD_EXMEM;
    else if (wb_we && wb_rd != 5'd0 && wb_rd == src)
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// forward_unit: combinational EX-stage ALU operand select.
// Ports: EX/MEM and MEM/WB dest/write-enable, ex_rs/ex_rt in; fwd_a/fwd_b out.
module forward_unit
  import mips_pkg::*;
(
  input  logic       mem_reg_write,
  input  logic [4:0] mem_write_reg,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_write_reg,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(mem_reg_write, mem_write_reg,
                         wb_reg_write, wb_write_reg, ex_rs);
  assign fwd_b = fwd_sel(mem_reg_write, mem_write_reg,
                         wb_reg_write, wb_write_reg, ex_rt);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stall, branch flush, fetch-miss
// freeze, forwarding. Ports: hazard inputs from ID/EX/MEM/WB; stage enables,
// flushes, pc_src, fwd_a/b, miss_timeout, state_o out. HAZARD_PERF_CNT_EN
// adds cnt_load_stall, cnt_branch_flush, cnt_miss_cycles.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_write_reg,
  input  logic [4:0]       wb_write_reg,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             miss_timeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] cnt_load_stall,
  output logic [CNT_W-1:0] cnt_branch_flush,
  output logic [CNT_W-1:0] cnt_miss_cycles,
`endif
  output logic [1:0]       state_o
);

  localparam int MCW = $clog2(MISS_TIMEOUT + 1);
  localparam logic [MCW-1:0] LIM = MCW'(MISS_TIMEOUT);

  hz_state_e      r_state;
  hz_state_e      w_next;
  logic [MCW-1:0] r_miss_cnt;
  logic [MCW-1:0] w_cnt_inc;
  logic           r_timeout;
  logic           w_branch;
  logic           w_load_use;
  logic           w_ld_stall;
  logic           w_miss_cyc;
  logic           w_unused;

  // ex_reg_write is not needed: a load always writes its destination.
  assign w_unused = ex_reg_write;

  assign w_branch = mem_branch & mem_zero;
  assign w_load_use = ex_mem_read && ex_write_reg != 5'd0 &&
                      (ex_write_reg == id_rs ||
                       (id_uses_rt && ex_write_reg == id_rt));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_src       = 1'b0;
    w_ld_stall   = 1'b0;
    w_next       = r_state;
    if (w_branch) begin
      pc_src       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      w_next       = ST_FLUSH;
    end else begin
      case (r_state)
        ST_FLUSH: begin
          // squash the fetch issued during the redirect
          if_id_flush = 1'b1;
          w_next      = hit ? ST_RUN : ST_MISS;
        end
        default: begin
          if (!hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            w_next       = ST_MISS;
          end else begin
            // resuming from MISS re-checks the frozen ID instruction
            w_next = ST_RUN;
            if (w_load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
              w_ld_stall  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign w_miss_cyc = (r_state == ST_MISS);
  assign w_cnt_inc  = (r_miss_cnt == LIM) ? LIM : r_miss_cnt + MCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_miss_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_miss_cyc && !hit && !w_branch) begin
        r_miss_cnt <= w_cnt_inc;
        if (w_cnt_inc == LIM)
          r_timeout <= 1'b1;
      end else begin
        r_miss_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load_stall   <= '0;
      cnt_branch_flush <= '0;
      cnt_miss_cycles  <= '0;
    end else begin
      if (w_ld_stall)
        cnt_load_stall <= cnt_load_stall + CNT_W'(1);
      if (w_branch)
        cnt_branch_flush <= cnt_branch_flush + CNT_W'(1);
      if (w_miss_cyc)
        cnt_miss_cycles <= cnt_miss_cycles + CNT_W'(1);
    end
  end
`endif

  assign miss_timeout = r_timeout;
  assign state_o      = r_state;

  forward_unit u_fwd (
    .mem_reg_write (mem_reg_write),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MISS_TIMEOUT=4).
// Linear stimulus with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hit;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read, ex_reg_write;
  logic [4:0] ex_rs, ex_rt, ex_write_reg;
  logic       mem_branch, mem_zero, mem_reg_write;
  logic [4:0] mem_write_reg, wb_write_reg;
  logic       wb_reg_write;
  logic       pc_write, if_id_write, id_ex_write;
  logic       ex_mem_write, mem_wb_write;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;
  logic       pc_src;
  logic [1:0] fwd_a, fwd_b;
  logic       miss_timeout;
  logic [1:0] state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hit           (hit),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_reg_write  (ex_reg_write),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_write_reg  (ex_write_reg),
    .mem_branch    (mem_branch),
    .mem_zero      (mem_zero),
    .mem_reg_write (mem_reg_write),
    .mem_write_reg (mem_write_reg),
    .wb_write_reg  (wb_write_reg),
    .wb_reg_write  (wb_reg_write),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .id_ex_write   (id_ex_write),
    .ex_mem_write  (ex_mem_write),
    .mem_wb_write  (mem_wb_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .pc_src        (pc_src),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .miss_timeout  (miss_timeout),
    .state_o       (state_o)
  );

  logic [4:0] w_en;
  logic [2:0] w_fl;
  assign w_en = {pc_write, if_id_write, id_ex_write,
                 ex_mem_write, mem_wb_write};
  assign w_fl = {if_id_flush, id_ex_flush, ex_mem_flush};

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // enables, flushes, pc_src, state in one shot
  task automatic chk_ctl(input string tag, input logic [4:0] en,
                         input logic [2:0] fl, input logic ps,
                         input logic [1:0] st);
    chk({tag, ".en"}, {3'b0, w_en}, {3'b0, en});
    chk({tag, ".fl"}, {5'b0, w_fl}, {5'b0, fl});
    chk({tag, ".pc_src"}, {7'b0, pc_src}, {7'b0, ps});
    chk({tag, ".state"}, {6'b0, state_o}, {6'b0, st});
  endtask

  task automatic idle();
    hit = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_write_reg = 5'd0;
    mem_branch = 1'b0; mem_zero = 1'b0;
    mem_reg_write = 1'b0; mem_write_reg = 5'd0;
    wb_reg_write = 1'b0; wb_write_reg = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    chk_ctl("rst", 5'b11111, 3'b000, 1'b0, 2'd0);
    chk("rst.fwd", {4'b0, fwd_a, fwd_b}, 8'h00);
    chk("rst.mto", {7'b0, miss_timeout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // lw $2 in EX, add $3,$2,$4 in ID
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    #1;
    chk_ctl("lu", 5'b00111, 3'b010, 1'b0, 2'd0);
    tick();
    // bubble in EX, lw in MEM
    idle();
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rt = 1'b1;
    mem_reg_write = 1'b1; mem_write_reg = 5'd2;
    #1;
    chk_ctl("lu.bub", 5'b11111, 3'b000, 1'b0, 2'd0);
    tick();
    // add in EX, lw in WB
    idle();
    ex_rs = 5'd2; ex_rt = 5'd4;
    wb_reg_write = 1'b1; wb_write_reg = 5'd2;
    #1;
    chk("lu.fwd_a", {6'b0, fwd_a}, 8'h01);
    chk("lu.fwd_b", {6'b0, fwd_b}, 8'h00);

    // rt match but instruction does not read rt: no stall
    idle();
    ex_mem_read = 1'b1; ex_write_reg = 5'd7;
    id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b0;
    #1;
    chk_ctl("lu.nort", 5'b11111, 3'b000, 1'b0, 2'd0);
    id_uses_rt = 1'b1;
    #1;
    chk_ctl("lu.rt", 5'b00111, 3'b010, 1'b0, 2'd0);
    // load to $0 never stalls
    ex_write_reg = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    chk_ctl("lu.r0", 5'b11111, 3'b000, 1'b0, 2'd0);
    tick();

    // add $2 in MEM, sub $5,$2,$2 in EX; WB also writes $2
    idle();
    mem_reg_write = 1'b1; mem_write_reg = 5'd2;
    wb_reg_write = 1'b1; wb_write_reg = 5'd2;
    ex_rs = 5'd2; ex_rt = 5'd2;
    #1;
    chk("fw.exmem", {4'b0, fwd_a, fwd_b}, 8'h0a);
    mem_write_reg = 5'd0; wb_write_reg = 5'd0;
    ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    chk("fw.r0", {4'b0, fwd_a, fwd_b}, 8'h00);
    mem_write_reg = 5'd9; wb_write_reg = 5'd3;
    ex_rs = 5'd3; ex_rt = 5'd9; mem_reg_write = 1'b0;
    #1;
    chk("fw.mix", {4'b0, fwd_a, fwd_b}, 8'h04);
    tick();

    // branch not taken
    idle();
    mem_branch = 1'b1; mem_zero = 1'b0;
    #1;
    chk_ctl("br.nt", 5'b11111, 3'b000, 1'b0, 2'd0);
    mem_zero = 1'b1;
    #1;
    chk_ctl("br.t", 5'b11111, 3'b111, 1'b1, 2'd0);
    tick();
    // FLUSH with a load-use present: suppressed
    idle();
    ex_mem_read = 1'b1; ex_write_reg = 5'd2; id_rs = 5'd2;
    #1;
    chk_ctl("br.fl", 5'b11111, 3'b100, 1'b0, 2'd2);
    tick();
    idle();
    #1;
    chk_ctl("br.run", 5'b11111, 3'b000, 1'b0, 2'd0);

    // hit low for 5 cycles
    hit = 1'b0;
    #1;
    chk_ctl("ms.c1", 5'b00000, 3'b000, 1'b0, 2'd0);
    tick();
    for (int i = 2; i <= 5; i++) begin
      chk_ctl($sformatf("ms.c%0d", i), 5'b00000, 3'b000, 1'b0, 2'd1);
      chk($sformatf("ms.mto%0d", i), {7'b0, miss_timeout}, 8'h00);
      tick();
    end
    hit = 1'b1;
    #1;
    chk_ctl("ms.res", 5'b11111, 3'b000, 1'b0, 2'd1);
    chk("ms.mto", {7'b0, miss_timeout}, 8'h01);
    tick();
    chk_ctl("ms.run", 5'b11111, 3'b000, 1'b0, 2'd0);
    chk("ms.mto2", {7'b0, miss_timeout}, 8'h01);

    // branch + miss + load-use together
    hit = 1'b0;
    mem_branch = 1'b1; mem_zero = 1'b1;
    ex_mem_read = 1'b1; ex_write_reg = 5'd4; id_rs = 5'd4;
    #1;
    chk_ctl("pri", 5'b11111, 3'b111, 1'b1, 2'd0);
    tick();
    idle();
    hit = 1'b0;
    #1;
    chk_ctl("pri.fl", 5'b11111, 3'b100, 1'b0, 2'd2);
    tick();
    chk_ctl("pri.ms", 5'b00000, 3'b000, 1'b0, 2'd1);

    // async reset during MISS
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst.ms.st", {6'b0, state_o}, 8'h00);
    chk("rst.ms.mto", {7'b0, miss_timeout}, 8'h00);
    hit = 1'b1;
    #1;
    chk_ctl("rst.ms", 5'b11111, 3'b000, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post.mto", {7'b0, miss_timeout}, 8'h00);
    chk_ctl("post", 5'b11111, 3'b000, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
